uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
Serial transmit end of the team's UART link. Accepts a parallel word from the host, frames it as 1 start bit (0), word_size data bits (LSB first) and 1 stop bit (1), then drives it onto Serial_out. Each bit is held for samples_per_bit cycles of Sample_clk, matching the receiver's oversampling rate, so Serial_out can be looped directly into the existing receiver's Serial_in.

Parameters:
word_size, 8, data bits per frame
samples_per_bit, 8, Sample_clk cycles per serial bit; must equal the receiver oversampling rate
Num_counter_bits, 4, width of the sample and bit counters; must hold word_size+1 and samples_per_bit-1

Ports:
Sample_clk  input  1  the single clock; all state updates on its rising edge
rst_b  input  1  reset, synchronous and active-low (Already decided)
Data_bus  input  word_size  parallel word from host
Load_XMT_datareg  input  1  load Data_bus into XMT_datareg
Byte_ready  input  1  host request: copy XMT_datareg into the shift register
T_byte  input  1  host request: start transmitting the loaded frame
Serial_out  output  1  serial line; idles high
Busy  output  1  high when state is waiting or sending
Xmt_done  output  1  one-cycle pulse when a frame's stop bit completes
XMT_datareg  output  word_size  holding register, brought out for display/debug
Bit_counter  output  Num_counter_bits  bits sent in the current frame, for display/debug

Behaviour:
- Reset (rst_b=0 at a Sample_clk edge) takes effect at that edge:
  - state=idle
  - XMT_shftreg (word_size+1 bits) = all ones, so Serial_out=1
  - XMT_datareg=0, Sample_counter=0, Bit_counter=0, Xmt_done=0
- Reset mid-frame aborts the frame; Serial_out is 1 after that edge.
- Serial_out = XMT_shftreg[0]. It is a registered output with no combinational path from the inputs.
- Load_XMT_datareg=1: XMT_datareg <= Data_bus on the next edge. This works in any state. It does not disturb a frame in progress, because the shift register is separate.
- State machine, three states: idle, waiting, sending.
  - idle:
    - Byte_ready=1: XMT_shftreg <= {XMT_datareg, 1'b1}; go to waiting. Serial_out stays 1.
    - T_byte is ignored in idle, including when it arrives in the same cycle as Byte_ready.
  - waiting:
    - T_byte=1: XMT_shftreg[0] <= 0 (start bit); clear both counters; go to sending.
    - Otherwise remain in waiting, holding Serial_out=1.
    - Byte_ready is ignored.
  - sending: Sample_counter increments every cycle. When Sample_counter == samples_per_bit-1:
    - Sample_counter <= 0.
    - If Bit_counter < word_size+1: shift right with 1 fill, XMT_shftreg <= {1'b1, XMT_shftreg[word_size:1]}; Bit_counter += 1.
    - Else (Bit_counter == word_size+1, stop bit complete): Bit_counter <= 0; go to idle; Xmt_done=1 for the following cycle only.
    - Byte_ready and T_byte are ignored in sending.
- Timing:
  - The start bit appears on the edge that samples T_byte.
  - Each bit lasts exactly samples_per_bit cycles.
  - One frame occupies (word_size+2)*samples_per_bit cycles; 80 with the defaults.
  - The next frame's Byte_ready is accepted on the first idle cycle.
- Busy = (state != idle). It is decoded directly from the state register.
- Counters never wrap. Sample_counter only increments in sending, and Bit_counter is bounded by word_size+1.
- Unused state encoding goes to idle on the next edge. Serial_out holds whatever XMT_shftreg[0] contains; reset clears it.

Decomposition:
- Shared package/header holds:
  - state encodings idle=2'b00, waiting=2'b01, sending=2'b10
  - default word_size and samples_per_bit, shared with the receiver so the two cannot drift
- Split as the receiver is split:
  - tx_control_unit: FSM, produces load_shftreg, start, shift, clr/inc counter strobes
  - tx_datapath_unit: registers, counters, flags SC_eq_last and BC_lt_frame
  - The top level only wires these two together.

Test Plan:
- Reset: hold rst_b=0 for 3 edges mid-frame -> Serial_out=1, Busy=0, Bit_counter=0, XMT_datareg=8'h00 after the first reset edge.
- Frame 8'hA5: Load_XMT_datareg, then Byte_ready, then T_byte -> Serial_out sequence 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles. Busy high 81 cycles (1 waiting + 80 sending). Xmt_done pulses once.
- Loopback: Serial_out drives the receiver's Serial_in with read_not_ready_in=0. Send 8'h3C, then 8'hFF back-to-back -> receiver RCV_datareg = 8'h3C, then 8'hFF; Error1=Error2=0.
- Ignored requests: T_byte in idle, Byte_ready+T_byte in the same idle cycle, Byte_ready during sending -> only legal transitions occur; the frame is bit-exact.
- Data reload mid-frame: Load 8'h0F during bit 3 of an 8'hF0 frame -> line still carries 8'hF0. The next frame carries 8'h0F.
- Stall in waiting: hold for 20 cycles without T_byte -> Serial_out=1 and Busy=1 throughout. The start bit begins on the edge that samples T_byte.

Source files
------------

// File: rtl/uart_transmitter_pkg.sv
// Shared definitions for the UART transmit path.
// The receiver uses the same frame defaults, so the two ends of the link stay matched.
package uart_transmitter_pkg;

    // Default frame geometry for the transmitter and the receiver.
    localparam int unsigned WORD_SIZE_DEFAULT        = 8;
    localparam int unsigned SAMPLES_PER_BIT_DEFAULT  = 8;
    localparam int unsigned NUM_COUNTER_BITS_DEFAULT = 4;

    // Transmit controller states. The encodings are fixed so that debug views
    // of the state register read the same on every build.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAITING = 2'b01,
        SENDING = 2'b10
    } tx_state_t;

endpackage

// File: rtl/uart_transmitter_control.sv
// Transmit controller.
// Sequences idle -> waiting -> sending and issues single-cycle strobes to the datapath.
module tx_control_unit
    import uart_transmitter_pkg::*;
(
    input  logic Sample_clk,
    input  logic rst_b,
    input  logic Byte_ready,
    input  logic T_byte,
    input  logic SC_eq_last,
    input  logic BC_lt_frame,
    output logic load_shftreg,
    output logic start,
    output logic shift,
    output logic clr_sample_counter,
    output logic inc_sample_counter,
    output logic clr_bit_counter,
    output logic inc_bit_counter,
    output logic Busy,
    output logic Xmt_done
);

    tx_state_t state;

    assign Busy = (state != IDLE);

    // Datapath strobes are decoded from the current state and inputs.
    // The start bit therefore lands on the edge that samples T_byte.
    always_comb begin
        load_shftreg       = 1'b0;
        start              = 1'b0;
        shift              = 1'b0;
        clr_sample_counter = 1'b0;
        inc_sample_counter = 1'b0;
        clr_bit_counter    = 1'b0;
        inc_bit_counter    = 1'b0;
        case (state)
            IDLE: begin
                load_shftreg = Byte_ready;
            end
            WAITING: begin
                if (T_byte) begin
                    start              = 1'b1;
                    clr_sample_counter = 1'b1;
                    clr_bit_counter    = 1'b1;
                end
            end
            SENDING: begin
                inc_sample_counter = 1'b1;
                if (SC_eq_last) begin
                    clr_sample_counter = 1'b1;
                    if (BC_lt_frame) begin
                        shift           = 1'b1;
                        inc_bit_counter = 1'b1;
                    end else begin
                        clr_bit_counter = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // State register and registered Xmt_done pulse. Illegal encodings return to idle.
    always_ff @(posedge Sample_clk) begin
        if (!rst_b) begin
            state    <= IDLE;
            Xmt_done <= 1'b0;
        end else begin
            Xmt_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Byte_ready) state <= WAITING;
                end
                WAITING: begin
                    if (T_byte) state <= SENDING;
                end
                SENDING: begin
                    if (SC_eq_last && !BC_lt_frame) begin
                        state    <= IDLE;
                        Xmt_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_transmitter_datapath.sv
// Transmit datapath.
// Holds the host holding register, the framing shift register and the
// sample and bit counters, and flags the counter limits to the controller.
module tx_datapath_unit
    import uart_transmitter_pkg::*;
#(
    parameter int unsigned word_size        = WORD_SIZE_DEFAULT,
    parameter int unsigned samples_per_bit  = SAMPLES_PER_BIT_DEFAULT,
    parameter int unsigned Num_counter_bits = NUM_COUNTER_BITS_DEFAULT
) (
    input  logic                        Sample_clk,
    input  logic                        rst_b,
    input  logic [word_size-1:0]        Data_bus,
    input  logic                        Load_XMT_datareg,
    input  logic                        load_shftreg,
    input  logic                        start,
    input  logic                        shift,
    input  logic                        clr_sample_counter,
    input  logic                        inc_sample_counter,
    input  logic                        clr_bit_counter,
    input  logic                        inc_bit_counter,
    output logic                        Serial_out,
    output logic [word_size-1:0]        XMT_datareg,
    output logic [Num_counter_bits-1:0] Bit_counter,
    output logic                        SC_eq_last,
    output logic                        BC_lt_frame
);

    localparam logic [Num_counter_bits-1:0] CNT_ONE    = 1;
    localparam logic [Num_counter_bits-1:0] SC_LAST    = Num_counter_bits'(samples_per_bit - 1);
    localparam logic [Num_counter_bits-1:0] BC_FRAME   = Num_counter_bits'(word_size + 1);

    logic [word_size:0]          XMT_shftreg;
    logic [Num_counter_bits-1:0] Sample_counter;

    // The line is taken straight from the shift register, so it is glitch-free
    // and has no combinational path from the inputs.
    assign Serial_out  = XMT_shftreg[0];
    assign SC_eq_last  = (Sample_counter == SC_LAST);
    assign BC_lt_frame = (Bit_counter < BC_FRAME);

    // Holding register: the host may reload it at any time, even mid-frame.
    always_ff @(posedge Sample_clk) begin
        if (!rst_b) begin
            XMT_datareg <= '0;
        end else if (Load_XMT_datareg) begin
            XMT_datareg <= Data_bus;
        end
    end

    // Frame shift register. Bit 0 drives the line, and the register refills with ones toward the stop bit.
    always_ff @(posedge Sample_clk) begin
        if (!rst_b) begin
            XMT_shftreg <= '1;
        end else if (load_shftreg) begin
            XMT_shftreg <= {XMT_datareg, 1'b1};
        end else if (start) begin
            XMT_shftreg[0] <= 1'b0;
        end else if (shift) begin
            XMT_shftreg <= {1'b1, XMT_shftreg[word_size:1]};
        end
    end

    // Sample counter: counts Sample_clk cycles within the current bit.
    always_ff @(posedge Sample_clk) begin
        if (!rst_b) begin
            Sample_counter <= '0;
        end else if (clr_sample_counter) begin
            Sample_counter <= '0;
        end else if (inc_sample_counter) begin
            Sample_counter <= Sample_counter + CNT_ONE;
        end
    end

    // Bit counter: counts the bits already shifted out in the current frame.
    always_ff @(posedge Sample_clk) begin
        if (!rst_b) begin
            Bit_counter <= '0;
        end else if (clr_bit_counter) begin
            Bit_counter <= '0;
        end else if (inc_bit_counter) begin
            Bit_counter <= Bit_counter + CNT_ONE;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter top level.
// Frames a host word as start, LSB-first data and stop bits on Serial_out.
// This level only wires the controller to the datapath.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int unsigned word_size        = WORD_SIZE_DEFAULT,
    parameter int unsigned samples_per_bit  = SAMPLES_PER_BIT_DEFAULT,
    parameter int unsigned Num_counter_bits = NUM_COUNTER_BITS_DEFAULT
) (
    input  logic                        Sample_clk,
    input  logic                        rst_b,
    input  logic [word_size-1:0]        Data_bus,
    input  logic                        Load_XMT_datareg,
    input  logic                        Byte_ready,
    input  logic                        T_byte,
    output logic                        Serial_out,
    output logic                        Busy,
    output logic                        Xmt_done,
    output logic [word_size-1:0]        XMT_datareg,
    output logic [Num_counter_bits-1:0] Bit_counter
);

    logic load_shftreg;
    logic start;
    logic shift;
    logic clr_sample_counter;
    logic inc_sample_counter;
    logic clr_bit_counter;
    logic inc_bit_counter;
    logic SC_eq_last;
    logic BC_lt_frame;

    tx_control_unit u_control (
        .Sample_clk         (Sample_clk),
        .rst_b              (rst_b),
        .Byte_ready         (Byte_ready),
        .T_byte             (T_byte),
        .SC_eq_last         (SC_eq_last),
        .BC_lt_frame        (BC_lt_frame),
        .load_shftreg       (load_shftreg),
        .start              (start),
        .shift              (shift),
        .clr_sample_counter (clr_sample_counter),
        .inc_sample_counter (inc_sample_counter),
        .clr_bit_counter    (clr_bit_counter),
        .inc_bit_counter    (inc_bit_counter),
        .Busy               (Busy),
        .Xmt_done           (Xmt_done)
    );

    tx_datapath_unit #(
        .word_size        (word_size),
        .samples_per_bit  (samples_per_bit),
        .Num_counter_bits (Num_counter_bits)
    ) u_datapath (
        .Sample_clk         (Sample_clk),
        .rst_b              (rst_b),
        .Data_bus           (Data_bus),
        .Load_XMT_datareg   (Load_XMT_datareg),
        .load_shftreg       (load_shftreg),
        .start              (start),
        .shift              (shift),
        .clr_sample_counter (clr_sample_counter),
        .inc_sample_counter (inc_sample_counter),
        .clr_bit_counter    (clr_bit_counter),
        .inc_bit_counter    (inc_bit_counter),
        .Serial_out         (Serial_out),
        .XMT_datareg        (XMT_datareg),
        .Bit_counter        (Bit_counter),
        .SC_eq_last         (SC_eq_last),
        .BC_lt_frame        (BC_lt_frame)
    );

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter.
// A frame-level model predicts every output on every cycle. Directed frames add literal line checks.
module tb_uart_transmitter;

    localparam int WS    = 8;
    localparam int SPB   = 8;
    localparam int NCB   = 4;
    localparam int FRAME = (WS + 2) * SPB;

    logic          Sample_clk       = 1'b0;
    logic          rst_b            = 1'b0;
    logic [WS-1:0] Data_bus         = '0;
    logic          Load_XMT_datareg = 1'b0;
    logic          Byte_ready       = 1'b0;
    logic          T_byte           = 1'b0;
    logic          Serial_out;
    logic          Busy;
    logic          Xmt_done;
    logic [WS-1:0] XMT_datareg;
    logic [NCB-1:0] Bit_counter;

    uart_transmitter #(
        .word_size        (WS),
        .samples_per_bit  (SPB),
        .Num_counter_bits (NCB)
    ) dut (
        .Sample_clk       (Sample_clk),
        .rst_b            (rst_b),
        .Data_bus         (Data_bus),
        .Load_XMT_datareg (Load_XMT_datareg),
        .Byte_ready       (Byte_ready),
        .T_byte           (T_byte),
        .Serial_out       (Serial_out),
        .Busy             (Busy),
        .Xmt_done         (Xmt_done),
        .XMT_datareg      (XMT_datareg),
        .Bit_counter      (Bit_counter)
    );

    always #5 Sample_clk = ~Sample_clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: mode 0 idle, 1 waiting, 2 sending; t is the number of cycles since the start bit.
    int            m_mode  = 0;
    int            m_t     = 0;
    logic [WS-1:0] m_datareg = '0;
    logic [WS-1:0] m_frame = '0;
    logic [WS-1:0] m_old;
    logic          m_done  = 1'b0;
    bit            m_valid = 1'b0;

    // Line level at cycle t of a frame: the start bit, then data bits LSB first, then the stop bit.
    function automatic int line_at(input logic [WS-1:0] w, input int t);
        int k;
        k = t / SPB;
        if (k == 0) return 0;
        if (k <= WS) return int'(w[k-1]);
        return 1;
    endfunction

    // Advance the model on each edge, then compare every output 1 time unit later.
    always @(posedge Sample_clk) begin
        if (!rst_b) begin
            m_mode = 0; m_t = 0; m_datareg = '0; m_done = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_old  = m_datareg;
            m_done = 1'b0;
            if (Load_XMT_datareg) m_datareg = Data_bus;
            case (m_mode)
                0: if (Byte_ready) begin m_frame = m_old; m_mode = 1; end
                1: if (T_byte) begin m_mode = 2; m_t = 0; end
                default: begin
                    if (m_t == FRAME - 1) begin m_mode = 0; m_done = 1'b1; end
                    else m_t++;
                end
            endcase
        end
        #1;
        if (m_valid) begin
            check("model_serial", int'(Serial_out), (m_mode == 2) ? line_at(m_frame, m_t) : 1);
            check("model_busy", int'(Busy), (m_mode != 0) ? 1 : 0);
            check("model_done", int'(Xmt_done), int'(m_done));
            check("model_datareg", int'(XMT_datareg), int'(m_datareg));
            check("model_bitcnt", int'(Bit_counter), (m_mode == 2) ? m_t / SPB : 0);
        end
    end

    // Drive one frame request and capture the line over a 90-cycle window.
    // The window starts on the cycle that presents T_byte.
    task automatic send_frame(input bit do_load, input logic [WS-1:0] d, input int stall,
                              input bit junk, input int reload_w, input logic [WS-1:0] reload_d,
                              output logic [9:0] bits, output int busy_n, output int done_n);
        @(negedge Sample_clk);
        Load_XMT_datareg = do_load; Data_bus = d; T_byte = junk;
        @(negedge Sample_clk);
        Load_XMT_datareg = 1'b0; Byte_ready = 1'b1; T_byte = junk;
        @(negedge Sample_clk);
        Byte_ready = 1'b0; T_byte = 1'b0;
        for (int s = 0; s < stall; s++) begin
            check("stall_busy", int'(Busy), 1);
            check("stall_line", int'(Serial_out), 1);
            @(negedge Sample_clk);
        end
        T_byte = 1'b1;
        busy_n = 0; done_n = 0; bits = '0;
        for (int w = 0; w < 90; w++) begin
            if (Busy) busy_n++;
            if (Xmt_done) done_n++;
            if (w >= 5 && ((w - 5) % SPB) == 0 && (w - 5) / SPB < 10)
                bits[(w - 5) / SPB] = Serial_out;
            if (w >= 1) begin
                T_byte     = junk && (w < 70);
                Byte_ready = junk && (w < 70) && (w % 3 == 0);
            end
            Load_XMT_datareg = (w == reload_w);
            Data_bus         = reload_d;
            @(negedge Sample_clk);
        end
        T_byte = 1'b0; Byte_ready = 1'b0; Load_XMT_datareg = 1'b0;
    endtask

    logic [9:0] bits;
    int         busy_n;
    int         done_n;

    initial begin
        repeat (2) @(negedge Sample_clk);
        rst_b = 1'b1;
        check("reset_line", int'(Serial_out), 1);
        check("reset_busy", int'(Busy), 0);
        check("reset_datareg", int'(XMT_datareg), 0);

        // Frame 8'hA5: the line must read 0,1,0,1,0,0,1,0,1,1 in time order.
        send_frame(1'b1, 8'hA5, 0, 1'b0, -1, 8'h00, bits, busy_n, done_n);
        check("a5_bits", int'(bits), 10'b1101001010);
        check("a5_busy_cycles", busy_n, 81);
        check("a5_done_pulses", done_n, 1);

        // Send two frames in sequence and decode the data bits from the line.
        send_frame(1'b1, 8'h3C, 0, 1'b0, -1, 8'h00, bits, busy_n, done_n);
        check("loop_3c", int'(bits[8:1]), 8'h3C);
        check("loop_3c_framing", int'({bits[9], bits[0]}), 2'b10);
        send_frame(1'b1, 8'hFF, 0, 1'b0, -1, 8'h00, bits, busy_n, done_n);
        check("loop_ff", int'(bits[8:1]), 8'hFF);

        // Requests arriving in illegal states are ignored, so the frame stays bit-exact.
        send_frame(1'b1, 8'h96, 0, 1'b1, -1, 8'h00, bits, busy_n, done_n);
        check("ignored_bits", int'(bits), 10'b1100101100);
        check("ignored_done", done_n, 1);

        // Reloading the holding register during data bit 3 must not disturb the frame on the line.
        send_frame(1'b1, 8'hF0, 0, 1'b0, 1 + 4 * SPB + 2, 8'h0F, bits, busy_n, done_n);
        check("reload_line", int'(bits[8:1]), 8'hF0);
        check("reload_reg", int'(XMT_datareg), 8'h0F);
        send_frame(1'b0, 8'h00, 0, 1'b0, -1, 8'h00, bits, busy_n, done_n);
        check("reload_next", int'(bits[8:1]), 8'h0F);

        // Stall in waiting for 20 cycles, then send the frame.
        send_frame(1'b1, 8'h5A, 20, 1'b0, -1, 8'h00, bits, busy_n, done_n);
        check("stall_bits", int'(bits[8:1]), 8'h5A);
        check("stall_busy_cycles", busy_n, 81);

        // Apply reset mid-frame for 3 edges.
        @(negedge Sample_clk);
        Load_XMT_datareg = 1'b1; Data_bus = 8'hC3;
        @(negedge Sample_clk);
        Load_XMT_datareg = 1'b0; Byte_ready = 1'b1;
        @(negedge Sample_clk);
        Byte_ready = 1'b0; T_byte = 1'b1;
        @(negedge Sample_clk);
        T_byte = 1'b0;
        repeat (30) @(negedge Sample_clk);
        rst_b = 1'b0;
        @(negedge Sample_clk);
        check("midreset_line", int'(Serial_out), 1);
        check("midreset_busy", int'(Busy), 0);
        check("midreset_bitcnt", int'(Bit_counter), 0);
        check("midreset_datareg", int'(XMT_datareg), 0);
        repeat (2) @(negedge Sample_clk);
        rst_b = 1'b1;

        // Random traffic. The per-cycle model checks every output.
        for (int c = 0; c < 4000; c++) begin
            rst_b            = ($urandom_range(0, 599) != 0);
            Load_XMT_datareg = ($urandom_range(0, 7) == 0);
            Data_bus         = WS'($urandom);
            Byte_ready       = ($urandom_range(0, 3) == 0);
            T_byte           = ($urandom_range(0, 3) == 0);
            @(negedge Sample_clk);
        end
        rst_b = 1'b1; Load_XMT_datareg = 1'b0; Byte_ready = 1'b0; T_byte = 1'b0;
        repeat (3) @(negedge Sample_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
